grant_bus_ctrl: RTL and testbench

Downstream consumer of the two-requester arbiter's grants. Takes `gnt_0`/`gnt_1`, locks the winning requester as bus owner, forwards a fixed-length burst of that requester's data beats onto a single shared output bus, and signals per-requester burst completion so the requester can drop its request. Sits between the arbiter and the shared resource (memory/peripheral write port).

---
 rtl/grant_bus_pkg.sv | 16 +
 rtl/beat_counter.sv | 30 +++
 rtl/grant_bus_ctrl.sv | 139 +++++++++++++
 tb/tb_grant_bus_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/grant_bus_pkg.sv
// Shared types and defaults for the grant-driven burst forwarder.
package grant_bus_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/beat_counter.sv
// Counts forwarded beats of one burst; flags the final beat position.
module beat_counter #(
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic increment,
  output logic last
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] cnt_q;

  // Cleared on every lock, so the count never needs to wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (increment) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/grant_bus_ctrl.sv
// Locks the granted requester and forwards its fixed-length burst onto one bus.
// GRANT_BUS_CTRL_PARITY_EN adds a registered even-parity output bus_par.
module grant_bus_ctrl
  import grant_bus_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] data_0,
  input  logic              valid_1,
  input  logic [DATA_W-1:0] data_1,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_owner,
  output logic              busy,
  output logic              done_0,
  output logic              done_1,
`ifdef GRANT_BUS_CTRL_PARITY_EN
  output logic              bus_par,
`endif
  output logic              abort
);

  state_e            state_q;
  logic              bus_valid_q;
  logic [DATA_W-1:0] bus_data_q;
  logic              bus_owner_q;
  logic              busy_q;
  logic              done_0_q;
  logic              done_1_q;
  logic              abort_q;

  logic              own_gnt;
  logic              own_valid;
  logic [DATA_W-1:0] own_data;
  logic              cnt_clear;
  logic              cnt_inc;
  logic              cnt_last;

  always_comb begin
    own_gnt   = (bus_owner_q == OWNER_1) ? gnt_1   : gnt_0;
    own_valid = (bus_owner_q == OWNER_1) ? valid_1 : valid_0;
    own_data  = (bus_owner_q == OWNER_1) ? data_1  : data_0;
    cnt_clear = (state_q == IDLE) && (gnt_0 || gnt_1);
    cnt_inc   = (state_q == XFER) && own_gnt && own_valid;
  end

  beat_counter #(.BURST_LEN(BURST_LEN)) u_beat_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .increment (cnt_inc),
    .last      (cnt_last)
  );

`ifdef GRANT_BUS_CTRL_PARITY_EN
  logic bus_par_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_owner_q <= OWNER_0;
      busy_q      <= 1'b0;
      done_0_q    <= 1'b0;
      done_1_q    <= 1'b0;
      abort_q     <= 1'b0;
`ifdef GRANT_BUS_CTRL_PARITY_EN
      bus_par_q   <= 1'b0;
`endif
    end else begin
      bus_valid_q <= 1'b0;
      done_0_q    <= 1'b0;
      done_1_q    <= 1'b0;
      abort_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // gnt_0 wins if both are asserted.
          if (gnt_0) begin
            bus_owner_q <= OWNER_0;
            busy_q      <= 1'b1;
            state_q     <= XFER;
          end else if (gnt_1) begin
            bus_owner_q <= OWNER_1;
            busy_q      <= 1'b1;
            state_q     <= XFER;
          end
        end
        XFER: begin
          if (!own_gnt) begin
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (own_valid) begin
            bus_valid_q <= 1'b1;
            bus_data_q  <= own_data;
`ifdef GRANT_BUS_CTRL_PARITY_EN
            bus_par_q   <= ^own_data;
`endif
            if (cnt_last) begin
              done_0_q <= (bus_owner_q == OWNER_0);
              done_1_q <= (bus_owner_q == OWNER_1);
              state_q  <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!own_gnt) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_data  = bus_data_q;
  assign bus_owner = bus_owner_q;
  assign busy      = busy_q;
  assign done_0    = done_0_q;
  assign done_1    = done_1_q;
  assign abort     = abort_q;
`ifdef GRANT_BUS_CTRL_PARITY_EN
  assign bus_par   = bus_par_q;
`endif

endmodule

// File: tb/tb_grant_bus_ctrl.sv
// Directed and randomized checks of grant_bus_ctrl against a burst-level reference model.
module tb_grant_bus_ctrl;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          gnt_0 = 1'b0, gnt_1 = 1'b0, valid_0 = 1'b0, valid_1 = 1'b0;
  logic [DW-1:0] data_0 = '0, data_1 = '0;
  logic          bus_valid, bus_owner, busy, done_0, done_1, abort;
  logic [DW-1:0] bus_data;
`ifdef GRANT_BUS_CTRL_PARITY_EN
  logic          bus_par;
`endif

  always #5 clk = ~clk;

  grant_bus_ctrl #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .valid_0   (valid_0),
    .data_0    (data_0),
    .valid_1   (valid_1),
    .data_1    (data_1),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_owner (bus_owner),
    .busy      (busy),
    .done_0    (done_0),
    .done_1    (done_1),
`ifdef GRANT_BUS_CTRL_PARITY_EN
    .bus_par   (bus_par),
`endif
    .abort     (abort)
  );

  int total = 0;
  int bad   = 0;
  int beats_seen = 0;
  int dones_seen = 0;

  // Reference: "locked" holds a burst; "beats" is how many of BL have gone out.
  logic          m_locked, m_sending, m_owner, m_bv, m_d0, m_d1, m_ab;
  logic [DW-1:0] m_data;
  int            m_beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_sending = 0; m_owner = 0; m_bv = 0;
    m_d0 = 0; m_d1 = 0; m_ab = 0; m_data = '0; m_beats = 0;
  endtask

  task automatic model_step();
    logic g, v;
    logic [DW-1:0] d;
    m_bv = 0; m_d0 = 0; m_d1 = 0; m_ab = 0;
    g = m_owner ? gnt_1 : gnt_0;
    v = m_owner ? valid_1 : valid_0;
    d = m_owner ? data_1 : data_0;
    if (!m_locked) begin
      if (gnt_0 || gnt_1) begin
        m_locked = 1; m_sending = 1; m_beats = 0;
        m_owner = gnt_0 ? 1'b0 : 1'b1;
      end
    end else if (m_sending) begin
      if (!g) begin
        m_ab = 1; m_locked = 0; m_sending = 0;
      end else if (v) begin
        m_bv = 1; m_data = d; m_beats++;
        if (m_beats == BL) begin
          m_sending = 0;
          if (m_owner) m_d1 = 1; else m_d0 = 1;
        end
      end
    end else if (!g) begin
      m_locked = 0;
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_locked);
    if (m_locked) chk("bus_owner", bus_owner, m_owner);
    chk("bus_valid", bus_valid, m_bv);
    chk("bus_data", bus_data, m_data);
    chk("done_0", done_0, m_d0);
    chk("done_1", done_1, m_d1);
    chk("abort", abort, m_ab);
`ifdef GRANT_BUS_CTRL_PARITY_EN
    chk("bus_par", bus_par, ^m_data);
`endif
    beats_seen += int'(bus_valid);
    dones_seen += int'(done_0) + int'(done_1);
  endtask

  task automatic cyc(input logic g0, input logic v0, input logic [DW-1:0] d0,
                     input logic g1, input logic v1, input logic [DW-1:0] d1);
    gnt_0 = g0; valid_0 = v0; data_0 = d0;
    gnt_1 = g1; valid_1 = v1; data_1 = d1;
    if (rst) model_step(); else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic rnd_cyc();
    cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
  endtask

  initial begin
    logic [DW-1:0] seq0 [4];
    logic          stall_pat [7];
    logic          rg0, rg1;
    seq0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    stall_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset held with toggling inputs.
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) rnd_cyc();
    chk("rst_owner", bus_owner, 1'b0);
    rst = 1'b1;
    cyc(0, 0, 8'h00, 0, 0, 8'h00);
    chk("idle_busy", busy, 1'b0);

    // Normal burst, owner 0.
    cyc(1, 1, 8'h11, 0, 0, 8'h00);
    chk("lock_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1, 1, seq0[i], 0, 0, 8'h00);
    chk("last_data", bus_data, 8'h44);
    chk("last_done0", done_0, 1'b1);
    cyc(1, 1, 8'h55, 0, 0, 8'h00);
    chk("release_busy", busy, 1'b1);
    chk("release_nobeat", bus_valid, 1'b0);
    cyc(0, 0, 8'h00, 0, 0, 8'h00);
    chk("release_idle", busy, 1'b0);

    // Stalls, owner 1.
    cyc(0, 0, 8'h00, 1, 0, 8'h00);
    beats_seen = 0; dones_seen = 0;
    for (int i = 0; i < 7; i++) cyc(0, 1, 8'hFF, 1, stall_pat[i], DW'(8'hA0 + i));
    chk("stall_beats", beats_seen, 4);
    chk("stall_dones", dones_seen, 1);
    chk("stall_done1", done_1, 1'b1);
    cyc(0, 0, 8'h00, 0, 0, 8'h00);

    // Abort after 2 beats, then a fresh burst from requester 1.
    cyc(1, 0, 8'h00, 0, 0, 8'h00);
    cyc(1, 1, 8'h61, 0, 0, 8'h00);
    cyc(1, 1, 8'h62, 0, 0, 8'h00);
    dones_seen = 0;
    cyc(0, 1, 8'h63, 0, 0, 8'h00);
    chk("abort_pulse", abort, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_dropped", bus_valid, 1'b0);
    cyc(0, 0, 8'h00, 1, 0, 8'h00);
    chk("abort_onepulse", abort, 1'b0);
    beats_seen = 0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 1, DW'(8'h71 + i));
    chk("after_abort_beats", beats_seen, 4);
    chk("after_abort_done1", done_1, 1'b1);
    chk("abort_no_done0", dones_seen, 1);
    cyc(0, 0, 8'h00, 0, 0, 8'h00);

    // Simultaneous grants: requester 0 wins.
    cyc(1, 1, 8'h5A, 1, 1, 8'hEE);
    chk("simul_owner", bus_owner, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, DW'(8'h5A + i), 1, 1, 8'hEE);
      chk("simul_not_d1", bus_data != 8'hEE, 1'b1);
    end
    cyc(0, 0, 8'h00, 0, 0, 8'h00);

`ifdef GRANT_BUS_CTRL_PARITY_EN
    cyc(1, 0, 8'h00, 0, 0, 8'h00);
    cyc(1, 1, 8'h03, 0, 0, 8'h00);
    chk("par_03", bus_par, 1'b0);
    cyc(1, 1, 8'h07, 0, 0, 8'h00);
    chk("par_07", bus_par, 1'b1);
    cyc(0, 0, 8'h00, 0, 0, 8'h00);
`endif

    // Asynchronous reset mid-burst.
    cyc(0, 0, 8'h00, 1, 0, 8'h00);
    cyc(0, 0, 8'h00, 1, 1, 8'h91);
    cyc(0, 0, 8'h00, 1, 1, 8'h92);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 8'h00, 0, 0, 8'h00);

    // Randomized traffic with sticky grants so bursts usually complete.
    rg0 = 0; rg1 = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 8) rg0 = ~rg0;
      if ($urandom_range(0, 99) < 8) rg1 = ~rg1;
      cyc(rg0, ($urandom_range(0, 99) < 70), DW'($urandom),
          rg1, ($urandom_range(0, 99) < 70), DW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
